// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with registered grant, owner release and hold timeout
module rr_arbiter16 #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [3:0] ptr, ptr_nxt, start, win, idx_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic rel, take;
  always_comb begin
    start = (state == GRANT) ? gnt_idx + 4'd1 : ptr;
    win = start;
    for (int i = 15; i >= 0; i--) if (req[start + 4'(i)]) win = start + 4'(i);
    rel = done || !req[gnt_idx] || hold_cnt == 8'(MAX_HOLD);
    take = (state == IDLE || rel) && |req;
    state_nxt = ((state == GRANT && !rel) || |req) ? GRANT : IDLE;
    ptr_nxt = (state == GRANT && rel) ? gnt_idx + 4'd1 : ptr;
    idx_nxt = take ? win : gnt_idx;
    hold_nxt = take ? 8'd1 : (state_nxt == IDLE) ? 8'd0 :
               (hold_cnt == 8'(MAX_HOLD)) ? hold_cnt : hold_cnt + 8'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_idx  <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt_idx  <= idx_nxt;
      gnt      <= (state_nxt == GRANT) ? 16'h1 << idx_nxt : '0;
    end
  end
  assign gnt_valid = state == GRANT;
endmodule
